pdp8_mem_arbiter: RTL
=====================

# pdp8_mem_arbiter

Single-port memory arbiter for the PDP-8 core. It shares one synchronous main memory between the instruction fetch/decode (IFD) read port and the execution unit's read and write ports. It grants one request per cycle, routes read data back to its owner one cycle later, and guarantees bounded fetch latency through a starvation counter. It sits between the IFD/EXEC units and the memory model, and it is the sole driver of the memory request bus.

## Interface
Parameters:
- ADDR_WIDTH, 12, address width (`ADDR_WIDTH from pdp8_pkg)
- DATA_WIDTH, 12, data width (`DATA_WIDTH from pdp8_pkg)
- STARVE_LIMIT, 2, maximum consecutive cycles an IFU request can lose arbitration; range 1..7

Ports:
- clk  in  1  single clock; everything is on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- ifu_rd_req  in  1  IFD read request; held until granted
- ifu_rd_addr  in  ADDR_WIDTH  IFD read address
- ifu_rd_gnt  out  1  IFD request accepted this cycle (combinational)
- ifu_rd_valid  out  1  ifu_rd_data valid (registered pulse)
- ifu_rd_data  out  DATA_WIDTH  IFD read data; holds the last returned value
- exec_rd_req  in  1  EXEC read request
- exec_rd_addr  in  ADDR_WIDTH  EXEC read address
- exec_rd_gnt  out  1  EXEC read accepted
- exec_rd_valid  out  1  exec_rd_data valid
- exec_rd_data  out  DATA_WIDTH  EXEC read data; holds the last returned value
- exec_wr_req  in  1  EXEC write request
- exec_wr_addr  in  ADDR_WIDTH  EXEC write address
- exec_wr_data  in  DATA_WIDTH  EXEC write data
- exec_wr_gnt  out  1  write accepted; the write is committed at the next rising edge
- mem_req  out  1  memory access this cycle
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read access

## Operation
- Arbitration each cycle, among asserted requests only:
  - If starve_cnt == STARVE_LIMIT and ifu_rd_req: IFU wins.
  - Otherwise exec_wr > exec_rd > ifu_rd.
- Exactly one gnt is high when any request is high; no gnt is high otherwise.
- Memory bus: mem_req = OR of the grants. mem_we, mem_addr and mem_wdata come from the granted port.
  - When idle, mem_addr and mem_wdata hold 0 and mem_we = 0.
- Response tracking: the registered field resp_owner is one of NONE, IFU or EXEC.
  - It is set at the edge ending a read grant.
  - It is set to NONE after a write or an idle cycle.
- Response cycle:
  - If resp_owner = IFU: ifu_rd_valid = 1, ifu_rd_data = mem_rdata, and ifu_data_hold captures mem_rdata.
  - If resp_owner = EXEC: the same applies on the exec port with exec_data_hold.
  - In all other cycles the data outputs drive their hold registers.
- starve_cnt is a 3-bit register:
  - It increments when ifu_rd_req = 1 and ifu_rd_gnt = 0.
  - It clears when ifu_rd_gnt = 1 or ifu_rd_req = 0.
  - It saturates at STARVE_LIMIT.
- Back-to-back grants to any port are allowed. A read grant and a response are in flight at the same time, so the block sustains one access per cycle.
- Read-after-write to the same address in consecutive cycles returns the new data, because the memory commits the write before the next read.
- Requests are not queued. A requester that drops req before gnt simply loses the slot.

## Timing
- Reset values, applied immediately on reset_n low:
  - All gnt and valid outputs = 0.
  - ifu_rd_data = 0 and exec_rd_data = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - starve_cnt = 0 and resp_owner = NONE.
- Grant latency is 0 cycles: gnt is combinational from req, starve_cnt and priority.
- Read latency: granted in cycle N means valid and data in cycle N+1.
- Write latency: granted in cycle N means the memory is updated at the N→N+1 edge.
- Worst-case IFU wait is STARVE_LIMIT cycles of continuous EXEC traffic. The IFU is granted in cycle STARVE_LIMIT, counting from its first request cycle as cycle 0.
- Reset during a response cycle: valid drops immediately and the in-flight data is discarded. After release, the first grant happens no earlier than the first rising edge with reset_n = 1.
- exec_rd and exec_wr asserted together: the write goes first and the read is granted the following cycle.
- All three requests asserted with starve_cnt = STARVE_LIMIT: the IFU is granted and the exec_wr waits.

## Test plan
- Reset: hold reset_n = 0 with all req = 1. Required: every output is 0. After release, the first cycle grants exec_wr.
- Single fetch: ifu_rd_req = 1 with addr = 12'o200 and memory[12'o200] = 12'o7001. Required: ifu_rd_gnt in cycle 0; ifu_rd_valid = 1 with data 12'o7001 in cycle 1; data holds 12'o7001 afterwards with valid = 0.
- Priority: exec_wr, exec_rd and ifu_rd all asserted with starve_cnt = 0. Required: grant order is wr, rd, ifu over 3 cycles when STARVE_LIMIT = 2. The IFU is granted in cycle 2 by the starvation rule.
- Starvation: continuous exec_rd plus ifu_rd_req with STARVE_LIMIT = 2. Required: the IFU is granted in cycle 2, EXEC is granted in cycles 0, 1 and 3, and starve_cnt returns to 0.
- Read-after-write: exec_wr of 12'o1234 to addr 12'o300 in cycle 0, then exec_rd of 12'o300 in cycle 1. Required: exec_rd_valid with data 12'o1234 in cycle 2.
- Reset mid-read: grant an IFU read in cycle N, then pulse reset_n low during cycle N+1. Required: ifu_rd_valid is 0 and ifu_rd_data is 0 while reset is low. After release there is no spurious valid.

Source files
------------

// File: rtl/pdp8_mem_arbiter.sv
// pdp8_mem_arbiter
// Shares one synchronous main memory between the IFD read port and the EXEC
// read/write ports. One access is granted per cycle. Read data returns to its
// owner one cycle after the grant. A starvation counter bounds how long a
// pending fetch can be held off by EXEC traffic.
//
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   ifu_rd_req/addr -> gnt        IFD read request, combinational grant
//   ifu_rd_valid/data             IFD read response (data holds last value)
//   exec_rd_req/addr -> gnt       EXEC read request, combinational grant
//   exec_rd_valid/data            EXEC read response (data holds last value)
//   exec_wr_req/addr/data -> gnt  EXEC write request, committed at next edge
//   mem_req/we/addr/wdata         memory request bus (zeros when idle)
//   mem_rdata                     memory read data, cycle after a read access
//
// Response owner table:
//   OWN_NONE | no read response this cycle
//   OWN_IFU  | mem_rdata belongs to the IFD port
//   OWN_EXEC | mem_rdata belongs to the EXEC read port
module pdp8_mem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 12,
  parameter int STARVE_LIMIT = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic                  ifu_rd_gnt,
  output logic                  ifu_rd_valid,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic                  exec_rd_gnt,
  output logic                  exec_rd_valid,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_gnt,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_EXEC = 2'd2
  } owner_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  owner_t                resp_owner;
  owner_t                resp_owner_nxt;
  logic [2:0]            starve_cnt;
  logic [2:0]            starve_cnt_nxt;
  logic [DATA_WIDTH-1:0] ifu_data_hold;
  logic [DATA_WIDTH-1:0] exec_data_hold;
  logic                  ifu_force;

  // A fetch that has waited STARVE_LIMIT cycles overrides the fixed priority.
  assign ifu_force = ifu_rd_req && (starve_cnt == LIMIT);

  // Grants are gated by reset_n so nothing is granted while reset is held,
  // even though the grant path is purely combinational.
  always_comb begin
    exec_wr_gnt = 1'b0;
    exec_rd_gnt = 1'b0;
    ifu_rd_gnt  = 1'b0;
    if (reset_n) begin
      if (ifu_force) begin
        ifu_rd_gnt = 1'b1;
      end else if (exec_wr_req) begin
        exec_wr_gnt = 1'b1;
      end else if (exec_rd_req) begin
        exec_rd_gnt = 1'b1;
      end else if (ifu_rd_req) begin
        ifu_rd_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_req   = exec_wr_gnt | exec_rd_gnt | ifu_rd_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (exec_wr_gnt) begin
      mem_we    = 1'b1;
      mem_addr  = exec_wr_addr;
      mem_wdata = exec_wr_data;
    end else if (exec_rd_gnt) begin
      mem_addr = exec_rd_addr;
    end else if (ifu_rd_gnt) begin
      mem_addr = ifu_rd_addr;
    end
  end

  always_comb begin
    resp_owner_nxt = OWN_NONE;
    if (ifu_rd_gnt) begin
      resp_owner_nxt = OWN_IFU;
    end else if (exec_rd_gnt) begin
      resp_owner_nxt = OWN_EXEC;
    end
  end

  always_comb begin
    starve_cnt_nxt = 3'd0;
    if (ifu_rd_req && !ifu_rd_gnt) begin
      starve_cnt_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_owner     <= OWN_NONE;
      starve_cnt     <= 3'd0;
      ifu_data_hold  <= '0;
      exec_data_hold <= '0;
    end else begin
      resp_owner <= resp_owner_nxt;
      starve_cnt <= starve_cnt_nxt;
      if (resp_owner == OWN_IFU) begin
        ifu_data_hold <= mem_rdata;
      end
      if (resp_owner == OWN_EXEC) begin
        exec_data_hold <= mem_rdata;
      end
    end
  end

  // During the response cycle data passes straight through from memory;
  // otherwise each port shows the last value it received.
  assign ifu_rd_valid  = (resp_owner == OWN_IFU);
  assign exec_rd_valid = (resp_owner == OWN_EXEC);
  assign ifu_rd_data   = ifu_rd_valid  ? mem_rdata : ifu_data_hold;
  assign exec_rd_data  = exec_rd_valid ? mem_rdata : exec_data_hold;

endmodule
